// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_AND = 3'd2;
  localparam op_t OP_OR  = 3'd3;
  localparam op_t OP_XOR = 3'd4;
  localparam op_t OP_LSH = 3'd5;
  localparam op_t OP_RSH = 3'd6;
  localparam op_t OP_ASR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  function automatic logic is_shift(input op_t op);
    return op >= OP_LSH;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Request/result handshake bundle between the register file side and writeback.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, op, in1, in2, out_ready,
    input  in_ready, out_valid, out, carry, overflow, zero, negative, busy
  );

  modport slave (
    input  in_valid, op, in1, in2, out_ready,
    output in_ready, out_valid, out, carry, overflow, zero, negative, busy
  );
endinterface

// File: rtl/alu_arith_core.sv
// Combinational add/sub/logic unit; shift opcodes are handled by the caller.
module alu_arith_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, result} = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {carry, result} = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle arithmetic/logic, bit-serial shifts, registered result and flags.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  reset,
  alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH + 1);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] out_q;
  flags_t           flags_q;

  logic [WIDTH-1:0] arith_res;
  logic             arith_carry;
  logic             arith_ovf;
  logic [SHW-1:0]   k_in;
  logic [WIDTH-1:0] acc_next;
  logic             bit_out;

  alu_arith_core #(.WIDTH(WIDTH)) u_arith (
    .op       (bus.op),
    .a        (bus.in1),
    .b        (bus.in2),
    .result   (arith_res),
    .carry    (arith_carry),
    .overflow (arith_ovf)
  );

  function automatic flags_t result_flags(input logic [WIDTH-1:0] v, input logic c, input logic o);
    return flags_t'{carry: c, overflow: o, zero: (v == '0), negative: v[WIDTH-1]};
  endfunction

  // Oversized shift amounts saturate at WIDTH steps.
  assign k_in = (bus.in2 >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : bus.in2[SHW-1:0];

  always_comb begin
    acc_next = acc;
    bit_out  = 1'b0;
    case (op_q)
      OP_LSH:  {bit_out, acc_next} = {acc, 1'b0};
      OP_RSH:  {acc_next, bit_out} = {1'b0, acc};
      OP_ASR:  {acc_next, bit_out} = {acc[WIDTH-1], acc};
      default: ;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      acc     <= '0;
      cnt     <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (!is_shift(bus.op)) begin
              out_q   <= arith_res;
              flags_q <= result_flags(arith_res, arith_carry, arith_ovf);
              state   <= ST_DONE;
            end else if (k_in == '0) begin
              out_q   <= bus.in1;
              flags_q <= result_flags(bus.in1, 1'b0, 1'b0);
              state   <= ST_DONE;
            end else begin
              acc   <= bus.in1;
              cnt   <= k_in;
              op_q  <= bus.op;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHW'(1);
          // The result only becomes visible once the last step is taken.
          if (cnt == SHW'(1)) begin
            out_q   <= acc_next;
            flags_q <= result_flags(acc_next, bit_out, 1'b0);
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_q   <= '0;
            flags_q <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out       = out_q;
  assign bus.carry     = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed cases with literal expectations plus randomized traffic.
module tb_alu_seq_core;

  logic clk = 1'b0;
  logic reset;

  alu_if #(.WIDTH(8)) bus ();

  alu_seq_core #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    int         k;
  } exp_t;

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ua, ub, sa, sb, r, k;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    k  = (ub >= 8) ? 8 : ub;
    e.res = 8'h00; e.c = 1'b0; e.v = 1'b0; e.k = 0;
    case (o)
      3'd0: begin
        r = ua + ub; e.res = r[7:0]; e.c = r[8];
        e.v = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        r = ua - ub; e.res = r[7:0]; e.c = (ua < ub);
        e.v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        r = ua << k; e.res = r[7:0]; e.c = (k > 0) ? r[8] : 1'b0; e.k = k;
      end
      3'd6: begin
        r = ua >> k; e.res = r[7:0]; e.k = k;
        if (k > 0) begin r = ua >> (k - 1); e.c = r[0]; end
      end
      default: begin
        r = sa >>> k; e.res = r[7:0]; e.k = k;
        if (k > 0) begin r = sa >>> (k - 1); e.c = r[0]; end
      end
    endcase
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    return e;
  endfunction

  // Transaction-level model: accepted request, cycles left until result, result held until taken.
  bit   m_live  = 1'b0;
  bit   m_busy  = 1'b0;
  bit   m_valid = 1'b0;
  int   m_wait  = 0;
  exp_t m_exp;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_wait = 0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_exp   = ref_op(bus.op, bus.in1, bus.in2);
          m_wait  = m_exp.k;
          m_busy  = 1'b1;
          m_valid = (m_wait == 0);
        end
      end else if (!m_valid) begin
        m_wait--;
        m_valid = (m_wait == 0);
      end else if (bus.out_ready) begin
        m_busy = 1'b0; m_valid = 1'b0;
      end
    end
  end

  logic [14:0] exp_vec, got_vec;

  always @(negedge clk) begin
    if (m_live) begin
      exp_vec = {!m_busy, m_busy, m_valid,
                 m_valid ? m_exp.res : 8'h00,
                 m_valid ? {m_exp.c, m_exp.v, m_exp.z, m_exp.n} : 4'h0};
      got_vec = {bus.in_ready, bus.busy, bus.out_valid, bus.out,
                 bus.carry, bus.overflow, bus.zero, bus.negative};
      check("cycle_outputs", 32'(got_vec), 32'(exp_vec));
    end
  end

  task automatic drive_junk();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.op       = 3'($urandom);
    bus.in1      = 8'($urandom);
    bus.in2      = 8'($urandom);
  endtask

  // Issue one request, measure accept-to-valid latency, hold for `stall` cycles, then drain.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input int stall, input int exp_lat,
                        output logic [7:0] r, output logic [3:0] f);
    int n, lat;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.in1       = a;
    bus.in2       = b;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      drive_junk();
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    r = bus.out;
    f = {bus.carry, bus.overflow, bus.zero, bus.negative};
    for (int i = 0; i < stall; i++) begin
      drive_junk();
      @(negedge clk);
      check("held_result", {18'd0, bus.out_valid, bus.in_ready, bus.out, bus.carry,
                            bus.overflow, bus.zero, bus.negative}, {18'd0, 1'b1, 1'b0, r, f});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drained", {30'd0, bus.out_valid, bus.in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  task automatic expect_res(input string name, input logic [7:0] r, input logic [3:0] f,
                            input logic [7:0] er, input logic [3:0] ef);
    check(name, {20'd0, r, f}, {20'd0, er, ef});
  endtask

  logic [7:0] r;
  logic [3:0] f;
  exp_t       e;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.in1 = 8'h00; bus.in2 = 8'h00; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", {19'd0, bus.in_ready, bus.busy, bus.out_valid, bus.out, bus.carry,
                          bus.overflow, bus.zero, bus.negative}, {19'd0, 1'b1, 1'b0, 1'b0, 12'h000});
    reset = 1'b0;
    @(negedge clk);

    // flags order {carry, overflow, zero, negative}
    run_op(3'd0, 8'h7F, 8'h01, 0, 1, r, f); expect_res("add_7f_01", r, f, 8'h80, 4'b0101);
    run_op(3'd1, 8'h05, 8'h07, 0, 1, r, f); expect_res("sub_05_07", r, f, 8'hFE, 4'b1001);
    run_op(3'd0, 8'hFF, 8'h01, 0, 1, r, f); expect_res("add_ff_01", r, f, 8'h00, 4'b1010);
    run_op(3'd5, 8'h21, 8'd3,  0, 4, r, f); expect_res("lsh_21_3",  r, f, 8'h08, 4'b1000);
    run_op(3'd6, 8'h21, 8'd0,  0, 1, r, f); expect_res("rsh_21_0",  r, f, 8'h21, 4'b0000);
    run_op(3'd7, 8'h90, 8'd10, 0, 9, r, f); expect_res("asr_90_10", r, f, 8'hFF, 4'b1001);
    run_op(3'd6, 8'h90, 8'd10, 0, 9, r, f); expect_res("rsh_90_10", r, f, 8'h00, 4'b1010);
    run_op(3'd4, 8'hAA, 8'hAA, 5, 1, r, f); expect_res("xor_aa_aa", r, f, 8'h00, 4'b0010);
    run_op(3'd1, 8'h80, 8'h01, 2, 1, r, f); expect_res("sub_80_01", r, f, 8'h7F, 4'b0100);

    // Reset lands in the third shift cycle of LSH by 6.
    bus.in_valid = 1'b1; bus.op = 3'd5; bus.in1 = 8'hC3; bus.in2 = 8'd6; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_shift", {19'd0, bus.in_ready, bus.busy, bus.out_valid, bus.out, bus.carry,
                              bus.overflow, bus.zero, bus.negative}, {19'd0, 1'b1, 1'b0, 1'b0, 12'h000});
    run_op(3'd0, 8'h01, 8'h02, 0, 1, r, f); expect_res("add_after_reset", r, f, 8'h03, 4'b0000);

    for (int i = 0; i < 200; i++) begin
      logic [2:0] o;
      logic [7:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = (o >= 3'd5 && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      e = ref_op(o, a, b);
      run_op(o, a, b, $urandom_range(0, 3), 1 + e.k, r, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the 4-bit arithmetic unit.
- Performs add, subtract, AND, OR and XOR in one cycle, and logical left, logical right and arithmetic right shifts by a variable amount, one bit per cycle.
- Every result is registered together with carry, overflow, zero and negative flags.
- Sits between the register file and the writeback stage, and uses valid/ready on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits; minimum 2.
- SHW, derived localparam = clog2(WIDTH+1), width of the shift counter; not overridable.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operation request present.
- in_ready, output, 1, block can accept a request; high only in IDLE.
- op, input, 3, opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSH, 6 RSH, 7 ASR.
- in1, input, WIDTH, first operand; the value shifted for shift ops.
- in2, input, WIDTH, second operand; the unsigned shift amount for shift ops.
- out_valid, output, 1, result and flags valid.
- out_ready, input, 1, consumer accepts the result.
- out, output, WIDTH, result.
- carry, output, 1, carry out (ADD), borrow (SUB), or last bit shifted out (shifts).
- overflow, output, 1, signed overflow for ADD and SUB; 0 for all other ops.
- zero, output, 1, out == 0.
- negative, output, 1, out[WIDTH-1].
- busy, output, 1, state != IDLE.

Behaviour:
- Reset:
  - state IDLE; out_valid 0, out 0, carry/overflow/zero/negative 0, busy 0, in_ready 1.
  - Reset overrides any in-flight operation, including one in SHIFT or DONE; the partial result is discarded.
- FSM states:
  - IDLE: in_ready=1. A request is accepted when in_valid && in_ready at a clock edge, and op/in1/in2 are captured on that edge. Inputs are ignored in every other cycle.
  - SHIFT: entered only for ops 5-7 with k = min(in2, WIDTH) > 0. The accumulator shifts one bit per cycle, the counter decrements, and the state moves to DONE after the k-th shift.
  - DONE: out_valid=1. out and all flags are held stable while out_ready=0. On out_ready=1 the state goes to IDLE on the same edge; out_valid drops the next cycle.
- Latency:
  - ops 0-4: accept at edge N, out_valid high from cycle N+1.
  - shifts: out_valid high from cycle N+1+k. k=0 goes straight to DONE with out=in1 and carry=0.
- Throughput: at most one operation per 2 cycles; there is no accept in DONE, even when out_ready=1.
- ADD: {carry, out} = in1 + in2 as a (WIDTH+1)-bit sum. overflow = (in1 and in2 have the same MSB) && (out MSB differs).
- SUB: out = in1 - in2 modulo 2^WIDTH. carry = 1 when in1 < in2 unsigned. overflow = (in1 and in2 MSBs differ) && (out MSB differs from in1 MSB).
- AND/OR/XOR: bitwise result; carry = 0, overflow = 0.
- LSH: zero-fill shift; carry = MSB shifted out on the final step.
- RSH: zero-fill shift; carry = LSB shifted out on the final step.
- ASR: sign-fill shift (MSB replicated); carry = LSB shifted out on the final step.
- Shift amount: any in2 >= WIDTH is clamped to k = WIDTH.
  - LSH/RSH then give 0.
  - ASR gives all copies of the in1 sign bit.
  - carry still follows the per-step rule.
- zero and negative are computed from the final out and are registered with it.
- During SHIFT: out, the flags and out_valid keep their reset/last-cleared values of 0. Intermediate accumulator values are never visible on out.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD..OP_ASR;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE;
  - a flag-bundle typedef {carry, overflow, zero, negative}.
- Sub-module alu_arith_core: combinational, WIDTH-parametrised add/sub/logic unit producing result, carry and overflow. The FSM, shift accumulator, counter and output registers stay in alu_seq_core.

Test Plan:
- WIDTH=8, ADD in1=0x7F in2=0x01 -> out_valid at N+1, out=0x80, carry=0, overflow=1, negative=1, zero=0.
- SUB in1=0x05 in2=0x07 -> out=0xFE, carry(borrow)=1, overflow=0, negative=1; then ADD 0xFF+0x01 -> out=0x00, carry=1, zero=1.
- LSH in1=0x21 in2=3 -> busy for cycles N+1..N+3, out_valid at N+4, out=0x08, carry=1; then RSH by 0 -> out=0x21, carry=0, latency 1.
- ASR in1=0x90 in2=10 (clamped to 8) -> out_valid at N+9, out=0xFF, carry=1, negative=1; RSH with the same operands -> out=0x00, zero=1, carry=1.
- Backpressure: XOR 0xAA^0xAA with out_ready=0 for 5 cycles -> out=0x00, zero=1 held stable, in_ready=0, concurrent in_valid ignored; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- Reset in the 3rd SHIFT cycle of LSH by 6 -> next cycle state IDLE, out_valid=0, out=0, all flags 0, in_ready=1; a following ADD 0x01+0x02 -> out=0x03 at accept+1.
